// File: rtl/adc_sample_scheduler.sv
// -----------------------------------------------------------------------------
// adc_sample_scheduler
//
// Sequences the ADC peak-detect/lookup datapath for one Ising round. For each
// sample it waits a programmed delay, runs the peak detector for a programmed
// window, waits for the looked-up values to arrive (DRAIN), then reports the
// value with the largest magnitude seen in that window.
//
// Optional feature macro: SCHED_TIMEOUT_EN
//   defined   : DRAIN gives up after DRAIN_TIMEOUT cycles and raises the sticky
//               timeout_err flag.
//   undefined : DRAIN waits indefinitely and timeout_err is tied to 0.
//
// Ports
//   clk           single clock
//   rst           synchronous reset, active-high
//   gpio_in       config bus: [15:0] addr, [23:16] data, [24] w_clk
//   start         one-cycle pulse, begin a round (ignored while busy)
//   abort         one-cycle pulse, cancel the round (wins over start)
//   run_out       peak-detector run enable to the ADC driver
//   val_in        looked-up signed value from the ADC driver
//   val_in_valid  qualifies val_in
//   sample_out    selected value for the current sample (signed, unmodified)
//   sample_idx    index of sample_out within the round
//   sample_valid  one-cycle strobe qualifying sample_out/sample_idx
//   busy          high in every state except IDLE
//   done          one-cycle strobe at normal round end
//   timeout_err   sticky drain-timeout flag
// -----------------------------------------------------------------------------
module adc_sample_scheduler #(
  parameter int VAL_W         = 8,
  parameter int DELAY_REG     = 3,
  parameter int WINDOW_REG    = 4,
  parameter int NSAMP_REG     = 5,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             gpio_in,
  input  logic                    start,
  input  logic                    abort,
  output logic                    run_out,
  input  logic signed [VAL_W-1:0] val_in,
  input  logic                    val_in_valid,
  output logic signed [VAL_W-1:0] sample_out,
  output logic [7:0]              sample_idx,
  output logic                    sample_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_WINDOW,
    S_DRAIN,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [VAL_W-1:0] MOST_NEG = {1'b1, {(VAL_W-1){1'b0}}};
  localparam logic [VAL_W-1:0] MAX_POS  = {1'b0, {(VAL_W-1){1'b1}}};

  state_t state, state_n;

  // ---------------------------------------------------------------------------
  // GPIO configuration port. w_clk comes from another domain: two flops to
  // synchronise, a third to find the rising edge. addr/data are assumed to be
  // held stable by the writer until well after w_clk rises.
  // ---------------------------------------------------------------------------
  logic       w_clk_meta, w_clk_sync, w_clk_prev;
  logic       gpio_wr;
  logic [7:0] cfg_delay, cfg_window, cfg_nsamp;

  assign gpio_wr = w_clk_sync & ~w_clk_prev;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_clk_meta <= 1'b0;
      w_clk_sync <= 1'b0;
      w_clk_prev <= 1'b0;
      cfg_delay  <= '0;
      cfg_window <= '0;
      cfg_nsamp  <= '0;
    end else begin
      w_clk_meta <= gpio_in[24];
      w_clk_sync <= w_clk_meta;
      w_clk_prev <= w_clk_sync;
      if (gpio_wr) begin
        if (gpio_in[15:0] == 16'(DELAY_REG))  cfg_delay  <= gpio_in[23:16];
        if (gpio_in[15:0] == 16'(WINDOW_REG)) cfg_window <= gpio_in[23:16];
        if (gpio_in[15:0] == 16'(NSAMP_REG))  cfg_nsamp  <= gpio_in[23:16];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round state: shadowed config, counters and best-value tracker
  // ---------------------------------------------------------------------------
  logic [7:0]             sh_delay, sh_nsamp, run_len;
  logic [7:0]             idx, dly_cnt, win_cnt;
  logic [8:0]             vld_cnt;
  logic [VAL_W-1:0]       val_mag, best_mag;
  logic signed [VAL_W-1:0] best_val;
  logic                   start_ok, tracking, take, drain_full, drain_expire;
  logic                   last_sample;

  assign start_ok    = (state == S_IDLE) && start && !abort;
  assign tracking    = (state == S_WINDOW) || (state == S_DRAIN);
  assign last_sample = (idx == sh_nsamp - 8'd1);
  // Drain completes in the cycle the final expected value is accepted, so the
  // tracker already holds it when EMIT is presented.
  assign drain_full  = (vld_cnt + 9'(val_in_valid)) == {1'b0, run_len};

  // |val_in| with the most negative code saturated so it fits in VAL_W-1 bits.
  always_comb begin
    val_mag = val_in;
    if (val_in == MOST_NEG)  val_mag = MAX_POS;
    else if (val_in[VAL_W-1]) val_mag = -val_in;
  end

  // Strictly greater: on equal magnitudes the earliest value is kept.
  assign take = tracking && val_in_valid && (val_mag > best_mag);

`ifdef SCHED_TIMEOUT_EN
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  logic [TW-1:0] drain_cnt;

  assign drain_expire = (state == S_DRAIN) && !drain_full &&
                        (drain_cnt == TW'(DRAIN_TIMEOUT - 1));

  // Abort does not clear the flag; only reset does.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + TW'(1) : '0;
      if (drain_expire) timeout_err <= 1'b1;
    end
  end
`else
  assign drain_expire = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // NOTE: state_n is given a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (cfg_nsamp == 8'd0)      state_n = S_DONE;
          else if (cfg_delay == 8'd0) state_n = S_WINDOW;
          else                        state_n = S_DELAY;
        end
      end
      S_DELAY:  if (dly_cnt == sh_delay - 8'd1) state_n = S_WINDOW;
      S_WINDOW: if (win_cnt == run_len - 8'd1)  state_n = S_DRAIN;
      S_DRAIN:  if (drain_full || drain_expire) state_n = S_EMIT;
      S_EMIT: begin
        if (last_sample)           state_n = S_DONE;
        else if (sh_delay == 8'd0) state_n = S_WINDOW;
        else                       state_n = S_DELAY;
      end
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (abort) state_n = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_delay <= '0;
      sh_nsamp <= '0;
      run_len  <= 8'd1;
      idx      <= '0;
      dly_cnt  <= '0;
      win_cnt  <= '0;
      vld_cnt  <= '0;
      best_mag <= '0;
      best_val <= '0;
    end else begin
      if (start_ok) begin
        sh_delay <= cfg_delay;
        sh_nsamp <= cfg_nsamp;
        run_len  <= (cfg_window == 8'd0) ? 8'd1 : cfg_window;
        idx      <= '0;
      end else if (state == S_EMIT && !last_sample) begin
        idx <= idx + 8'd1;
      end

      // Counters rest at zero outside their state, so entry needs no extra load.
      dly_cnt <= (state == S_DELAY)  ? dly_cnt + 8'd1 : '0;
      win_cnt <= (state == S_WINDOW) ? win_cnt + 8'd1 : '0;
      vld_cnt <= tracking ? vld_cnt + 9'(val_in_valid) : '0;

      // A missing sample behaves as value 0, which never displaces the
      // cleared tracker, so a timed-out window reports 0.
      if (state_n == S_WINDOW && state != S_WINDOW) begin
        best_mag <= '0;
        best_val <= '0;
      end else if (take) begin
        best_mag <= val_mag;
        best_val <= val_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from the state register
  // ---------------------------------------------------------------------------
  assign run_out      = (state == S_WINDOW);
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign sample_valid = (state == S_EMIT);
  assign sample_out   = sample_valid ? best_val : '0;
  assign sample_idx   = sample_valid ? idx : '0;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_scheduler
//
// Directed bench for adc_sample_scheduler with VAL_W=8. A small ADC model
// returns one value from adc_vals for every cycle run_out is high, adc_lat
// cycles later. Each test task drives one scenario and compares the recorded
// behaviour against hand-computed values.
// -----------------------------------------------------------------------------
module tb_adc_sample_scheduler;

  localparam int VAL_W = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [31:0]             gpio_in = '0;
  logic                    start = 1'b0;
  logic                    abort = 1'b0;
  logic                    run_out;
  logic signed [VAL_W-1:0] val_in = '0;
  logic                    val_in_valid = 1'b0;
  logic signed [VAL_W-1:0] sample_out;
  logic [7:0]              sample_idx;
  logic                    sample_valid;
  logic                    busy;
  logic                    done;
  logic                    timeout_err;

  adc_sample_scheduler #(
    .VAL_W        (VAL_W),
    .DELAY_REG    (3),
    .WINDOW_REG   (4),
    .NSAMP_REG    (5),
    .DRAIN_TIMEOUT(64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .gpio_in     (gpio_in),
    .start       (start),
    .abort       (abort),
    .run_out     (run_out),
    .val_in      (val_in),
    .val_in_valid(val_in_valid),
    .sample_out  (sample_out),
    .sample_idx  (sample_idx),
    .sample_valid(sample_valid),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------------------------------------------------------------------
  // ADC model
  // ---------------------------------------------------------------------------
  logic signed [VAL_W-1:0] adc_vals [16];
  int                      adc_ptr = 0;
  int                      adc_lat = 1;
  bit                      adc_en  = 1'b1;
  bit                      sr_v [17];
  logic signed [VAL_W-1:0] sr_d [17];

  initial begin
    for (int i = 0; i < 17; i++) begin
      sr_v[i] = 1'b0;
      sr_d[i] = '0;
    end
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 16; i++) begin
        sr_v[i] = sr_v[i+1];
        sr_d[i] = sr_d[i+1];
      end
      sr_v[16] = 1'b0;
      sr_d[16] = '0;
      if (run_out && adc_en) begin
        sr_v[adc_lat] = 1'b1;
        sr_d[adc_lat] = adc_vals[adc_ptr & 15];
        adc_ptr++;
      end
      val_in_valid = sr_v[0];
      val_in       = sr_d[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus / recording helpers (no comparisons here)
  // ---------------------------------------------------------------------------
  int                      run_first, run_last, run_total, nrise;
  int                      r_first [8];
  int                      ns;
  logic signed [VAL_W-1:0] s_val [8];
  int                      s_idx [8];
  int                      s_cyc [8];
  int                      done_cyc, done_count;
  logic                    busy_after;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gpio_write(input int addr, input int data);
    gpio_in = {7'd0, 1'b0, 8'(data), 16'(addr)};
    tick();
    gpio_in[24] = 1'b1;
    repeat (4) tick();
    gpio_in[24] = 1'b0;
    repeat (3) tick();
  endtask

  task automatic set_cfg(input int dly, input int win, input int nsamp);
    gpio_write(3, dly);
    gpio_write(4, win);
    gpio_write(5, nsamp);
  endtask

  // Start edge is cycle T; on return the bench observes cycle T+1.
  task automatic pulse_start();
    adc_ptr = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Records cycles T+1..T+max_cyc, optionally stopping one cycle after done.
  task automatic watch(input int max_cyc, input bit stop_on_done);
    bit stop;
    bit prev_run;
    run_first = -1; run_last = -1; run_total = 0; nrise = 0;
    ns = 0; done_cyc = -1; done_count = 0; busy_after = 1'bx;
    stop = 1'b0; prev_run = 1'b0;
    for (int k = 1; k <= max_cyc && !stop; k++) begin
      if (k > 1) tick();
      if (run_out) begin
        if (run_first < 0) run_first = k;
        run_last = k;
        run_total++;
        if (!prev_run && nrise < 8) begin
          r_first[nrise] = k;
          nrise++;
        end
      end
      prev_run = run_out;
      if (sample_valid && ns < 8) begin
        s_val[ns] = sample_out;
        s_idx[ns] = int'(sample_idx);
        s_cyc[ns] = k;
        ns++;
      end
      if (done) begin
        done_cyc = k;
        done_count++;
        if (stop_on_done) begin
          tick();
          busy_after = busy;
          stop = 1'b1;
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [6:0] got;
    rst = 1'b1;
    repeat (3) tick();
    got = {run_out, busy, done, sample_valid, timeout_err, |sample_out, |sample_idx};
    tests++;
    if (got !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b, expected 0000000", got);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_single_sample();
    set_cfg(2, 3, 1);
    adc_lat = 2;
    adc_vals[0] = 8'sd5; adc_vals[1] = -8'sd9; adc_vals[2] = 8'sd7;
    pulse_start();
    watch(40, 1'b1);
    tests++;
    if (run_first !== 3 || run_last !== 5 || run_total !== 3) begin
      fails++;
      $display("FAIL single_run_timing: first=%0d last=%0d total=%0d, expected 3 5 3",
               run_first, run_last, run_total);
    end
    tests++;
    if (ns !== 1 || s_val[0] !== -8'sd9 || s_idx[0] !== 0) begin
      fails++;
      $display("FAIL single_sample: n=%0d val=%0d idx=%0d, expected 1 -9 0",
               ns, s_val[0], s_idx[0]);
    end
    tests++;
    if (done_count !== 1 || done_cyc !== s_cyc[0] + 1 || busy_after !== 1'b0) begin
      fails++;
      $display("FAIL single_done: count=%0d cyc=%0d emit=%0d busy_after=%b, expected 1 emit+1 0",
               done_count, done_cyc, s_cyc[0], busy_after);
    end
  endtask

  task automatic test_multi_sample();
    set_cfg(1, 1, 3);
    adc_lat = 4;
    adc_vals[0] = 8'sd1; adc_vals[1] = 8'sd2; adc_vals[2] = 8'sd3;
    pulse_start();
    watch(80, 1'b1);
    tests++;
    if (ns !== 3 || run_total !== 3) begin
      fails++;
      $display("FAIL multi_count: samples=%0d run_cycles=%0d, expected 3 3", ns, run_total);
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (s_idx[i] !== i || s_val[i] !== 8'(i + 1)) begin
          fails++;
          $display("FAIL multi_sample%0d: idx=%0d val=%0d, expected %0d %0d",
                   i, s_idx[i], s_val[i], i, i + 1);
        end
      end
      tests++;
      if (r_first[1] !== s_cyc[0] + 2) begin
        fails++;
        $display("FAIL multi_delay_from_emit: run rise=%0d, expected %0d",
                 r_first[1], s_cyc[0] + 2);
      end
    end
    tests++;
    if (done_cyc !== s_cyc[2] + 1 || busy_after !== 1'b0) begin
      fails++;
      $display("FAIL multi_done: done=%0d busy_after=%b, expected %0d 0",
               done_cyc, busy_after, s_cyc[2] + 1);
    end
  endtask

  task automatic test_edge_values();
    set_cfg(0, 2, 1);
    adc_lat = 1;
    adc_vals[0] = -8'sd128; adc_vals[1] = 8'sd127;
    pulse_start();
    watch(40, 1'b1);
    tests++;
    if (run_first !== 1 || run_total !== 2) begin
      fails++;
      $display("FAIL edge_zero_delay: first=%0d total=%0d, expected 1 2", run_first, run_total);
    end
    tests++;
    if (ns !== 1 || s_val[0] !== -8'sd128) begin
      fails++;
      $display("FAIL edge_tie_neg_first: n=%0d val=%0d, expected 1 -128", ns, s_val[0]);
    end
    adc_vals[0] = -8'sd127; adc_vals[1] = -8'sd128;
    pulse_start();
    watch(40, 1'b1);
    tests++;
    if (ns !== 1 || s_val[0] !== -8'sd127) begin
      fails++;
      $display("FAIL edge_saturation: n=%0d val=%0d, expected 1 -127", ns, s_val[0]);
    end
    set_cfg(0, 2, 0);
    pulse_start();
    watch(10, 1'b1);
    tests++;
    if (done_cyc !== 1 || run_total !== 0 || ns !== 0 || busy_after !== 1'b0) begin
      fails++;
      $display("FAIL edge_nsamp0: done=%0d run=%0d samples=%0d busy_after=%b, expected 1 0 0 0",
               done_cyc, run_total, ns, busy_after);
    end
  endtask

  task automatic test_abort();
    set_cfg(1, 4, 1);
    adc_lat = 1;
    adc_vals[0] = 8'sd4; adc_vals[1] = 8'sd6; adc_vals[2] = -8'sd2; adc_vals[3] = 8'sd1;
    pulse_start();
    tick();
    tests++;
    if (run_out !== 1'b1) begin
      fails++;
      $display("FAIL abort_in_window: run_out=%b before abort, expected 1", run_out);
    end
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    tests++;
    if (run_out !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_next_cycle: run_out=%b busy=%b, expected 0 0", run_out, busy);
    end
    watch(20, 1'b0);
    tests++;
    if (ns !== 0 || done_count !== 0 || run_total !== 0) begin
      fails++;
      $display("FAIL abort_quiet: samples=%0d done=%0d run=%0d, expected 0 0 0",
               ns, done_count, run_total);
    end
    pulse_start();
    watch(40, 1'b1);
    tests++;
    if (ns !== 1 || s_val[0] !== 8'sd6 || run_total !== 4 || done_count !== 1) begin
      fails++;
      $display("FAIL abort_recover: samples=%0d val=%0d run=%0d done=%0d, expected 1 6 4 1",
               ns, s_val[0], run_total, done_count);
    end
  endtask

  task automatic test_config_shadow();
    set_cfg(1, 3, 1);
    adc_lat = 0;
    adc_vals[0] = 8'sd1; adc_vals[1] = -8'sd2; adc_vals[2] = 8'sd3;
    adc_vals[3] = -8'sd4; adc_vals[4] = 8'sd5;
    pulse_start();
    fork
      watch(60, 1'b1);
      gpio_write(4, 5);
    join
    tests++;
    if (run_total !== 3 || ns !== 1 || s_val[0] !== 8'sd3) begin
      fails++;
      $display("FAIL shadow_current: run=%0d samples=%0d val=%0d, expected 3 1 3",
               run_total, ns, s_val[0]);
    end
    pulse_start();
    watch(60, 1'b1);
    tests++;
    if (run_total !== 5 || ns !== 1 || s_val[0] !== 8'sd5) begin
      fails++;
      $display("FAIL shadow_next: run=%0d samples=%0d val=%0d, expected 5 1 5",
               run_total, ns, s_val[0]);
    end
  endtask

  task automatic test_drain_timeout();
    set_cfg(0, 2, 1);
    adc_en = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    pulse_start();
    watch(120, 1'b1);
    tests++;
    if (ns !== 1 || s_val[0] !== 8'sd0 || s_cyc[0] !== run_last + 65) begin
      fails++;
      $display("FAIL timeout_emit: samples=%0d val=%0d emit=%0d, expected 1 0 %0d",
               ns, s_val[0], s_cyc[0], run_last + 65);
    end
    tests++;
    if (timeout_err !== 1'b1 || done_count !== 1) begin
      fails++;
      $display("FAIL timeout_flag: timeout_err=%b done=%0d, expected 1 1", timeout_err, done_count);
    end
    adc_en = 1'b1;
    pulse_start();
    watch(40, 1'b1);
    tests++;
    if (timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL timeout_sticky: timeout_err=%b, expected 1", timeout_err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if (timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_rst_clear: timeout_err=%b, expected 0", timeout_err);
    end
`else
    pulse_start();
    watch(120, 1'b0);
    tests++;
    if (ns !== 0 || done_count !== 0 || busy !== 1'b1 || timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL drain_wait: samples=%0d done=%0d busy=%b timeout_err=%b, expected 0 0 1 0",
               ns, done_count, busy, timeout_err);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL drain_abort: busy=%b, expected 0", busy);
    end
`endif
    adc_en = 1'b1;
  endtask

  task automatic test_reset_mid_round();
    set_cfg(5, 3, 2);
    pulse_start();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0 || run_out !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_idle: busy=%b run_out=%b, expected 0 0", busy, run_out);
    end
    repeat (3) tick();
    pulse_start();
    watch(10, 1'b1);
    tests++;
    if (done_cyc !== 1 || run_total !== 0 || ns !== 0) begin
      fails++;
      $display("FAIL rst_cfg_cleared: done=%0d run=%0d samples=%0d, expected 1 0 0",
               done_cyc, run_total, ns);
    end
  endtask

  initial begin
    test_reset();
    test_single_sample();
    test_multi_sample();
    test_edge_values();
    test_abort();
    test_config_shadow();
    test_drain_timeout();
    test_reset_mid_round();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
